alien_bullet_ctrl: RTL and testbench

Downstream consumer of the alien formation block's alien_x/alien_y positions and alien_shoot pulse. It spawns falling alien bullets from a round-robin-selected alien, advances them on each frame move tick, and retires them at the screen bottom or on a player hit. It drives the renderer (bullet positions/valid) and game control (player_hit).

---
 rtl/game_pkg.sv | 17 +
 rtl/alien_bullet_slot.sv | 84 ++++++++
 rtl/alien_bullet_ctrl.sv | 116 +++++++++++
 tb/tb_alien_bullet_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared playfield and sprite geometry for the alien game blocks.
// Used as parameter defaults by the formation and bullet controllers.
package game_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int ALIEN_W  = 16;
  localparam int ALIEN_H  = 16;

  localparam int PLAYER_Y = 440;
  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 16;

endpackage

// File: rtl/alien_bullet_slot.sv
// One alien bullet slot: load, fall on move, retire at bottom, hitbox test.
// Ports: clk/reset, load/load_x/load_y, move, clear, player_x -> valid, x, y, hit.
module alien_bullet_slot #(
  parameter int BULLET_SPEED = 2,
  parameter int SCREEN_H     = game_pkg::SCREEN_H,
  parameter int PLAYER_Y     = game_pkg::PLAYER_Y,
  parameter int PLAYER_W     = game_pkg::PLAYER_W,
  parameter int PLAYER_H     = game_pkg::PLAYER_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [game_pkg::X_W-1:0] load_x,
  input  logic [game_pkg::Y_W-1:0] load_y,
  input  logic                     move,
  input  logic                     clear,
  input  logic [game_pkg::X_W-1:0] player_x,
  output logic                     valid,
  output logic [game_pkg::X_W-1:0] x,
  output logic [game_pkg::Y_W-1:0] y,
  output logic                     hit
);

  import game_pkg::*;

  localparam int BW = X_W + 1;
  localparam int YN = Y_W + 1;

  logic             valid_q, valid_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [YN-1:0]    y_nxt;
  logic [BW-1:0]    x_lo, x_hi, xb, yb;

  assign y_nxt = {1'b0, y_q} + YN'(BULLET_SPEED);

  // hitbox bounds are widened so player_x + PLAYER_W never wraps
  assign xb   = {1'b0, x_q};
  assign yb   = BW'(y_q);
  assign x_lo = {1'b0, player_x};
  assign x_hi = x_lo + BW'(PLAYER_W);

  assign hit = valid_q
             && (xb >= x_lo) && (xb < x_hi)
             && (yb >= BW'(PLAYER_Y))
             && (yb < BW'(PLAYER_Y + PLAYER_H));

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    priority case (1'b1)
      clear: valid_d = 1'b0;
      move && valid_q: begin
        // a retired bullet keeps its last on-screen y
        if (y_nxt >= YN'(SCREEN_H)) valid_d = 1'b0;
        else y_d = y_nxt[Y_W-1:0];
      end
      load: begin
        valid_d = 1'b1;
        x_d     = load_x;
        y_d     = load_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid = valid_q;
  assign x     = x_q;
  assign y     = y_q;

endmodule

// File: rtl/alien_bullet_ctrl.sv
// Alien bullet controller: round-robin shooter, slot allocation, hit/drop pulses.
// Ports: clk/reset, move_tick, alien_shoot, alien x/y buses, player_x -> bullets, player_hit, shot_dropped.
module alien_bullet_ctrl #(
  parameter int NUM_ALIENS   = 5,
  parameter int NUM_BULLETS  = 4,
  parameter int BULLET_SPEED = 2,
  parameter int SCREEN_H     = game_pkg::SCREEN_H,
  parameter int ALIEN_W      = game_pkg::ALIEN_W,
  parameter int ALIEN_H      = game_pkg::ALIEN_H,
  parameter int PLAYER_Y     = game_pkg::PLAYER_Y,
  parameter int PLAYER_W     = game_pkg::PLAYER_W,
  parameter int PLAYER_H     = game_pkg::PLAYER_H
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 move_tick,
  input  logic                                 alien_shoot,
  input  logic [game_pkg::X_W*NUM_ALIENS-1:0]  alien_x_flat,
  input  logic [game_pkg::Y_W*NUM_ALIENS-1:0]  alien_y_flat,
  input  logic [game_pkg::X_W-1:0]             player_x,
  output logic [NUM_BULLETS-1:0]               bullet_valid,
  output logic [game_pkg::X_W*NUM_BULLETS-1:0] bullet_x_flat,
  output logic [game_pkg::Y_W*NUM_BULLETS-1:0] bullet_y_flat,
  output logic                                 player_hit,
  output logic                                 shot_dropped
);

  import game_pkg::*;

  localparam int PW = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   hit_q, hit_d;
  logic                   drop_q, drop_d;
  logic [NUM_BULLETS-1:0] valid, hit, sel, load;
  logic                   any_free, spawn_ok, accept;
  logic [X_W-1:0]         ax;
  logic [Y_W-1:0]         ay;
  logic [XS-1:0]          sx;
  logic [YS-1:0]          sy;

  assign ax = alien_x_flat[int'(ptr_q)*X_W +: X_W];
  assign ay = alien_y_flat[int'(ptr_q)*Y_W +: Y_W];
  assign sx = {1'b0, ax} + XS'(ALIEN_W / 2);
  assign sy = {1'b0, ay} + YS'(ALIEN_H);

  assign spawn_ok = (sx <= XS'((1 << X_W) - 1))
                 && (sy <  YS'(SCREEN_H));

  // lowest free slot, judged on registered valid only
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!valid[i] && !any_free) begin
        sel[i]   = 1'b1;
        any_free = 1'b1;
      end
    end
  end

  assign accept = alien_shoot && any_free && spawn_ok;
  assign load   = accept ? sel : '0;

  always_comb begin
    ptr_d  = ptr_q;
    drop_d = alien_shoot && !accept;
    hit_d  = |hit;
    if (accept) begin
      if (ptr_q == PW'(NUM_ALIENS - 1)) ptr_d = '0;
      else ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      hit_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      hit_q  <= hit_d;
      drop_q <= drop_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    alien_bullet_slot #(
      .BULLET_SPEED(BULLET_SPEED),
      .SCREEN_H    (SCREEN_H),
      .PLAYER_Y    (PLAYER_Y),
      .PLAYER_W    (PLAYER_W),
      .PLAYER_H    (PLAYER_H)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (load[g]),
      .load_x  (sx[X_W-1:0]),
      .load_y  (sy[Y_W-1:0]),
      .move    (move_tick),
      .clear   (hit[g]),
      .player_x(player_x),
      .valid   (valid[g]),
      .x       (bullet_x_flat[g*X_W +: X_W]),
      .y       (bullet_y_flat[g*Y_W +: Y_W]),
      .hit     (hit[g])
    );
  end

  assign bullet_valid = valid;
  assign player_hit   = hit_q;
  assign shot_dropped = drop_q;

endmodule

// File: tb/tb_alien_bullet_ctrl.sv
// Self-checking bench for alien_bullet_ctrl.
// Vector table plus hand sequences; expectations flow through a scoreboard queue.
module tb_alien_bullet_ctrl;

  localparam int NA = 5;
  localparam int NB = 4;
  localparam logic [9:0] PF = 10'd900;

  logic          clk = 1'b0;
  logic          reset;
  logic          move_tick;
  logic          alien_shoot;
  logic [10*NA-1:0] alien_x_flat;
  logic [9*NA-1:0]  alien_y_flat;
  logic [9:0]    player_x;
  logic [NB-1:0] bullet_valid;
  logic [10*NB-1:0] bullet_x_flat;
  logic [9*NB-1:0]  bullet_y_flat;
  logic          player_hit;
  logic          shot_dropped;

  always #5 clk = ~clk;

  alien_bullet_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .move_tick    (move_tick),
    .alien_shoot  (alien_shoot),
    .alien_x_flat (alien_x_flat),
    .alien_y_flat (alien_y_flat),
    .player_x     (player_x),
    .bullet_valid (bullet_valid),
    .bullet_x_flat(bullet_x_flat),
    .bullet_y_flat(bullet_y_flat),
    .player_hit   (player_hit),
    .shot_dropped (shot_dropped)
  );

  typedef struct {
    logic       rst, mv, sh;
    logic [9:0] px, ax;
    logic [8:0] ay;
    logic [3:0] ev;
    logic       eh, ed;
    int         ps;
    logic [9:0] ex;
    logic [8:0] ey;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic rst, mv, sh,
    input logic [9:0] px, ax,
    input logic [8:0] ay,
    input logic [3:0] ev,
    input logic eh, ed,
    input int ps,
    input logic [9:0] ex,
    input logic [8:0] ey,
    input string nm);
    vec_t v;
    v.rst = rst; v.mv = mv; v.sh = sh;
    v.px = px; v.ax = ax; v.ay = ay;
    v.ev = ev; v.eh = eh; v.ed = ed;
    v.ps = ps; v.ex = ex; v.ey = ey;
    v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %0d want %0d", nm, what, act, exp);
    end
  endtask

  // alien i sits at (ax + 40*i, ay)
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    move_tick   = v.mv;
    alien_shoot = v.sh;
    player_x    = v.px;
    for (int i = 0; i < NA; i++) begin
      alien_x_flat[i*10 +: 10] = v.ax + 10'(40 * i);
      alien_y_flat[i*9 +: 9]   = v.ay;
    end
    sb.push_back(v);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        vec_t e;
        e = sb.pop_front();
        chk(e.nm, "valid", 32'(bullet_valid), 32'(e.ev));
        chk(e.nm, "hit", 32'(player_hit), 32'(e.eh));
        chk(e.nm, "drop", 32'(shot_dropped), 32'(e.ed));
        if (e.ps >= 0) begin
          chk(e.nm, "x", 32'(bullet_x_flat[e.ps*10 +: 10]), 32'(e.ex));
          chk(e.nm, "y", 32'(bullet_y_flat[e.ps*9 +: 9]), 32'(e.ey));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; move_tick = 1'b0; alien_shoot = 1'b0;
    player_x = PF; alien_x_flat = '0; alien_y_flat = '0;

    // spawn, fill, drop, move, reset mid-flight
    tbl.push_back(mk(1,0,0,PF,100,50,4'b0000,0,0,0,0,0,"reset"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b0001,0,0,0,108,66,"spawn0"));
    tbl.push_back(mk(0,0,0,PF,100,50,4'b0001,0,0,1,0,0,"idle"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b0011,0,0,1,148,66,"spawn1"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b0111,0,0,2,188,66,"spawn2"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b1111,0,0,3,228,66,"spawn3"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b1111,0,1,3,228,66,"drop_full"));
    tbl.push_back(mk(0,0,0,PF,100,50,4'b1111,0,0,0,108,66,"drop_end"));
    tbl.push_back(mk(0,1,0,PF,100,50,4'b1111,0,0,0,108,68,"move"));
    tbl.push_back(mk(1,1,1,PF,100,50,4'b0000,0,0,0,0,0,"reset_mid"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b0001,0,0,0,108,66,"ptr_reset"));
    // bottom retire and spawn/move coincidence
    tbl.push_back(mk(1,0,0,PF,100,50,4'b0000,0,0,-1,0,0,"rst2"));
    tbl.push_back(mk(0,0,1,PF,100,462,4'b0001,0,0,0,108,478,"spawn478"));
    tbl.push_back(mk(0,0,1,PF,100,460,4'b0011,0,0,1,148,476,"spawn476"));
    tbl.push_back(mk(0,1,0,PF,100,50,4'b0010,0,0,1,148,478,"move_keep"));
    tbl.push_back(mk(0,0,0,PF,100,50,4'b0010,0,0,0,108,478,"retire_hold"));
    tbl.push_back(mk(0,1,1,PF,100,50,4'b0001,0,0,0,188,66,"spawn_no_move"));
    // hits, x boundaries, double hit with drop
    tbl.push_back(mk(1,0,0,PF,100,50,4'b0000,0,0,-1,0,0,"rst3"));
    tbl.push_back(mk(0,0,1,PF,100,424,4'b0001,0,0,0,108,440,"spawn_in_box"));
    tbl.push_back(mk(0,0,0,100,100,50,4'b0000,1,0,-1,0,0,"hit"));
    tbl.push_back(mk(0,0,0,100,100,50,4'b0000,0,0,-1,0,0,"hit_end"));
    tbl.push_back(mk(0,0,1,PF,100,424,4'b0001,0,0,0,148,440,"fill0"));
    tbl.push_back(mk(0,0,1,PF,70,424,4'b0011,0,0,1,158,440,"fill1"));
    tbl.push_back(mk(0,0,1,PF,100,424,4'b0111,0,0,2,228,440,"fill2"));
    tbl.push_back(mk(0,0,1,PF,100,424,4'b1111,0,0,3,268,440,"fill3"));
    tbl.push_back(mk(0,0,0,116,100,424,4'b1111,0,0,-1,0,0,"hit_xhi_miss"));
    tbl.push_back(mk(0,0,0,159,100,424,4'b1111,0,0,-1,0,0,"hit_xlo_miss"));
    tbl.push_back(mk(0,0,1,127,100,50,4'b1100,1,1,-1,0,0,"two_hit_drop"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b1101,0,0,0,108,66,"ptr_kept"));
    // y boundaries and out-of-range spawns
    tbl.push_back(mk(1,0,0,PF,100,50,4'b0000,0,0,-1,0,0,"rst4"));
    tbl.push_back(mk(0,0,1,PF,100,423,4'b0001,0,0,0,108,439,"spawn439"));
    tbl.push_back(mk(0,0,0,100,100,50,4'b0001,0,0,0,108,439,"hit_ylo_miss"));
    tbl.push_back(mk(0,1,0,100,100,50,4'b0001,0,0,0,108,441,"move_in"));
    tbl.push_back(mk(0,0,0,100,100,50,4'b0000,1,0,-1,0,0,"hit_y"));
    tbl.push_back(mk(0,0,1,PF,100,440,4'b0001,0,0,0,148,456,"spawn456"));
    tbl.push_back(mk(0,0,0,140,100,50,4'b0001,0,0,0,148,456,"hit_yhi_miss"));
    tbl.push_back(mk(0,0,1,PF,100,470,4'b0001,0,1,1,0,0,"drop_oor_y"));
    tbl.push_back(mk(0,0,1,PF,100,50,4'b0011,0,0,1,188,66,"ptr_after_oor"));
    tbl.push_back(mk(0,0,1,PF,900,50,4'b0011,0,1,2,0,0,"drop_oor_x"));
    tbl.push_back(mk(0,0,1,PF,895,50,4'b0111,0,0,2,1023,66,"spawn_x1023"));
    tbl.push_back(mk(1,0,0,PF,100,50,4'b0000,0,0,0,0,0,"rst5"));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // long fall into the player: hit clear wins over a coincident move
    apply(mk(0,0,1,PF,100,400,4'b0001,0,0,0,108,416,"fly_spawn"));
    for (int k = 1; k <= 12; k++)
      apply(mk(0,1,0,100,100,50,4'b0001,0,0,0,108,9'(416 + 2*k),"fly"));
    apply(mk(0,1,0,100,100,50,4'b0000,1,0,-1,0,0,"fly_hit"));
    apply(mk(0,0,0,100,100,50,4'b0000,0,0,-1,0,0,"fly_hit_end"));

    @(negedge clk);
    @(negedge clk);
    chk("drain", "pending", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
